// File: rtl/hwpe_stream_package.sv
// Shared types for the side-channel TCDM stream source: control bundle,
// status flags and the source FSM encoding.
package hwpe_stream_package;

  // Length width of the control bundle; the source's CNT_WIDTH must match it.
  localparam int unsigned SIDECH_CNT_WIDTH = 16;

  typedef struct packed {
    logic [31:0]                 base_addr;
    logic [31:0]                 stride;
    logic [SIDECH_CNT_WIDTH-1:0] len;
  } ctrl_source_tcdm_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_source_tcdm_t;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_ISSUE = 2'd1,
    SRC_DRAIN = 2'd2,
    SRC_DONE  = 2'd3
  } source_state_e;

  function automatic logic [31:0] addr_step(input logic [31:0] addr,
                                            input logic [31:0] stride);
    return addr + stride;
  endfunction

endpackage

// File: rtl/hwpe_stream_addressgen_linear.sv
// Linear address generator: word address accumulator, request index and
// the flag marking the final request of a transfer.
module hwpe_stream_addressgen_linear
  import hwpe_stream_package::*;
#(
  parameter int unsigned CNT_WIDTH = SIDECH_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 step_i,
  output logic [31:0]          addr_o,
  output logic                 last_o
);

  logic [31:0]          r_addr;
  logic [31:0]          r_stride;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_idx    <= '0;
    end else if (clear_i) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_idx    <= '0;
    end else if (load_i) begin
      r_addr   <= base_addr_i;
      r_stride <= stride_i;
      r_len    <= len_i;
      r_idx    <= '0;
    end else if (step_i) begin
      r_addr   <= addr_step(r_addr, r_stride);
      r_idx    <= r_idx + 1'b1;
    end
  end

  assign addr_o = r_addr;
  assign last_o = (r_idx == r_len - 1'b1);

endmodule

// File: rtl/hwpe_stream_source_tcdm_sidech.sv
// Strided load source: issues tagged TCDM reads toward the side-channel
// FIFO and forwards the returned words as a stream with a last flag.
module hwpe_stream_source_tcdm_sidech
  import hwpe_stream_package::*;
#(
  parameter int unsigned CNT_WIDTH       = SIDECH_CNT_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 sidech_o,
  input  logic                 sidech_i,
  output logic                 ready_o,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o,
  output logic                 last_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  source_state_e      r_state;
  source_state_e      w_state_next;
  logic [OUT_W-1:0]   r_outstanding;
  logic [OUT_W-1:0]   w_outstanding_next;
  ctrl_source_tcdm_t  w_ctrl;
  flags_source_tcdm_t w_flags;
  logic               w_load;
  logic               w_req;
  logic               w_issue;
  logic               w_consume;
  logic               w_last_hs;
  logic               w_gen_last;
  logic [31:0]        w_addr;

  assign w_ctrl.base_addr = base_addr_i;
  assign w_ctrl.stride    = stride_i;
  assign w_ctrl.len       = len_i;

  assign w_req     = (r_state == SRC_ISSUE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign w_issue   = w_req & tcdm_gnt_i;
  assign w_consume = tcdm_r_valid_i & stream_ready_i;
  assign w_last_hs = w_consume & sidech_i;

  hwpe_stream_addressgen_linear #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_addressgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .load_i      (w_load),
    .base_addr_i (w_ctrl.base_addr),
    .stride_i    (w_ctrl.stride),
    .len_i       (w_ctrl.len),
    .step_i      (w_issue),
    .addr_o      (w_addr),
    .last_o      (w_gen_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      SRC_IDLE: begin
        if (start_i) begin
          if (w_ctrl.len != '0) begin
            w_load       = 1'b1;
            w_state_next = SRC_ISSUE;
          end else begin
            w_state_next = SRC_DONE;
          end
        end
      end
      SRC_ISSUE: begin
        if (w_issue && w_gen_last) w_state_next = SRC_DRAIN;
      end
      SRC_DRAIN: begin
        if (w_last_hs) w_state_next = SRC_DONE;
      end
      SRC_DONE: begin
        w_state_next = SRC_IDLE;
      end
      default: begin
        w_state_next = SRC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SRC_IDLE;
    end else if (clear_i) begin
      r_state <= SRC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A grant and a consumed response in the same cycle cancel out.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_issue && !w_consume) begin
      w_outstanding_next = r_outstanding + OUT_W'(1);
    end else if (!w_issue && w_consume && (r_outstanding != '0)) begin
      w_outstanding_next = r_outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (clear_i) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
    end
  end

  assign w_flags.busy = (r_state != SRC_IDLE);
  assign w_flags.done = (r_state == SRC_DONE);
  assign busy_o       = w_flags.busy;
  assign done_o       = w_flags.done;

  assign tcdm_req_o  = w_req;
  assign tcdm_add_o  = w_addr;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = '1;
  assign tcdm_data_o = '0;
  assign sidech_o    = (r_state == SRC_ISSUE) & w_gen_last;

  // Response path is purely combinational: FIFO output straight to stream.
  assign stream_valid_o = tcdm_r_valid_i;
  assign stream_data_o  = tcdm_r_data_i;
  assign stream_strb_o  = '1;
  assign ready_o        = stream_ready_i;
  assign last_o         = sidech_i & tcdm_r_valid_i;

  a_out_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_outstanding <= OUT_W'(MAX_OUTSTANDING));

  a_out_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    w_consume |-> (r_outstanding != '0));

  a_last_in_drain : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    (last_o && stream_ready_i) |-> (r_state == SRC_DRAIN));

endmodule

// File: tb/tb_hwpe_stream_source_tcdm_sidech.sv
// Self-checking bench for hwpe_stream_source_tcdm_sidech with a behavioural
// side-channel FIFO that answers each granted load with address-derived data.
module tb_hwpe_stream_source_tcdm_sidech;

  localparam int CW = 16;
  localparam int MO = 8;
  localparam logic [31:0] KEY = 32'hC3A5_0F1E;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [31:0]   stride = '0;
  logic [CW-1:0] len = '0;
  logic          busy, done_o;
  logic          req, gnt;
  logic [31:0]   add, wdata;
  logic          wen;
  logic [3:0]    be, strb;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          sidech_o, sidech_i, ready_o;
  logic          s_valid, s_ready, last_o;
  logic [31:0]   s_data;

  hwpe_stream_source_tcdm_sidech #(.CNT_WIDTH(CW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .base_addr_i(base_addr), .stride_i(stride), .len_i(len),
    .busy_o(busy), .done_o(done_o),
    .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
    .tcdm_be_o(be), .tcdm_data_o(wdata), .tcdm_r_data_i(r_data), .tcdm_r_valid_i(r_valid),
    .sidech_o(sidech_o), .sidech_i(sidech_i), .ready_o(ready_o),
    .stream_valid_o(s_valid), .stream_ready_i(s_ready), .stream_data_o(s_data),
    .stream_strb_o(strb), .last_o(last_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { logic [31:0] d; logic t; } rsp_t;
  rsp_t        fifo[$];
  logic [31:0] exp_adds[$];
  logic [31:0] got_adds[$];
  int exp_len = 0, grant_idx = 0, beat_idx = 0, out_cnt = 0, both_cnt = 0;
  int gnt_pct = 100, rdy_pct = 100;
  bit prev_last_hs = 0, zl_pend = 0, done_seen = 0, chk_internal = 0;
  bit hs_req = 0, hs_rsp = 0, clr_pend = 0, hs_tag = 0;
  logic [31:0] hs_add = '0;

  // Observe every handshake mid-cycle; the FIFO model applies it after the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      hs_req = req & gnt;
      hs_rsp = s_valid & s_ready;
      hs_add = add;
      hs_tag = sidech_o;
      clr_pend = clear;
      if (clear) begin
        prev_last_hs = 0;
        zl_pend = 0;
        out_cnt = 0;
      end else begin
        chk("done_pulse", 32'(done_o), 32'(prev_last_hs | zl_pend));
        if (done_o) done_seen = 1;
        if (chk_internal) chk("outstanding", 32'(dut.r_outstanding), 32'(out_cnt));
        zl_pend = start && (len == '0);
        prev_last_hs = 0;
        if (hs_req) begin
          chk("grant_in_range", 32'(grant_idx < exp_len), 32'd1);
          if (grant_idx < exp_len) chk("req_add", add, exp_adds[grant_idx]);
          chk("sidech_o", 32'(sidech_o), 32'(grant_idx == exp_len - 1));
          chk("wen_be_wdata", {27'd0, wen, be}, 32'h1F);
          chk("wdata_zero", wdata, 32'd0);
          got_adds.push_back(add);
          grant_idx++;
        end
        if (hs_rsp) begin
          chk("beat_in_range", 32'(beat_idx < exp_len), 32'd1);
          if (beat_idx < exp_len) chk("beat_data", s_data, exp_adds[beat_idx] ^ KEY);
          chk("last_o", 32'(last_o), 32'(beat_idx == exp_len - 1));
          chk("strb", 32'(strb), 32'hF);
          prev_last_hs = (beat_idx == exp_len - 1);
          beat_idx++;
        end
        if (hs_req && hs_rsp) both_cnt++;
        else if (hs_req) out_cnt++;
        else if (hs_rsp) out_cnt--;
        if (hs_req) chk("out_bound", 32'(out_cnt <= MO), 32'd1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (clr_pend) begin
      fifo.delete();
    end else begin
      if (hs_rsp && fifo.size() > 0) void'(fifo.pop_front());
      if (hs_req) fifo.push_back('{hs_add ^ KEY, hs_tag});
    end
    hs_req = 0;
    hs_rsp = 0;
    clr_pend = 0;
    gnt = ($urandom_range(99, 0) < gnt_pct);
    s_ready = ($urandom_range(99, 0) < rdy_pct);
    r_valid = (fifo.size() > 0);
    r_data = r_valid ? fifo[0].d : 32'd0;
    sidech_i = r_valid ? fifo[0].t : 1'b0;
  end

  task automatic prep(input logic [31:0] b, input logic [31:0] s, input int n);
    exp_adds.delete();
    got_adds.delete();
    for (int i = 0; i < n; i++) exp_adds.push_back(b + s * 32'(i));
    exp_len = n;
    grant_idx = 0;
    beat_idx = 0;
    done_seen = 0;
    base_addr = b;
    stride = s;
    len = CW'(n);
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(done_seen), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    int          n;
    int          gpct;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] alast;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h0000_1000, 32'd4,         4, 100, 32'h0000_1000, 32'h0000_1004, 32'h0000_100C};
    vecs[1] = '{32'hFFFF_FFF8, 32'd8,         3, 100, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFC, 5, 50,  32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0};
    vecs[3] = '{32'h0000_2000, 32'h100,       1, 50,  32'h0000_2000, 32'h0000_2000, 32'h0000_2000};

    gnt = 1'b1; s_ready = 1'b1; r_valid = 1'b0; r_data = '0; sidech_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_sidech", 32'(sidech_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      gnt_pct = vecs[v].gpct;
      rdy_pct = 100;
      prep(vecs[v].base, vecs[v].stride, vecs[v].n);
      kick();
      wait_done(200, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_grants", v), 32'(grant_idx), 32'(vecs[v].n));
      chk($sformatf("vec%0d_beats", v), 32'(beat_idx), 32'(vecs[v].n));
      if (got_adds.size() > 0) begin
        chk($sformatf("vec%0d_first_add", v), got_adds[0], vecs[v].a0);
        chk($sformatf("vec%0d_last_add", v), got_adds[got_adds.size() - 1], vecs[v].alast);
      end
      if (got_adds.size() > 1) chk($sformatf("vec%0d_second_add", v), got_adds[1], vecs[v].a1);
    end

    // Zero length: DONE straight from IDLE, no requests.
    prep(32'h0000_3000, 32'd4, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zl_busy_hi", 32'(busy), 32'd1);
    chk("zl_done_hi", 32'(done_o), 32'd1);
    @(negedge clk);
    chk("zl_busy_lo", 32'(busy), 32'd0);
    chk("zl_done_lo", 32'(done_o), 32'd0);
    chk("zl_no_req", 32'(grant_idx), 32'd0);

    // Back-pressure: stream stalled, requests stop at MAX_OUTSTANDING.
    gnt_pct = 100;
    rdy_pct = 0;
    prep(32'h0000_4000, 32'd4, 20);
    kick();
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_grants", 32'(grant_idx), 32'd8);
    chk("bp_req_low", 32'(req), 32'd0);
    chk("bp_no_beats", 32'(beat_idx), 32'd0);
    rdy_pct = 100;
    wait_done(300, "bp");
    chk("bp_beats", 32'(beat_idx), 32'd20);

    // Random grant, start while busy, then clear mid-ISSUE.
    gnt_pct = 50;
    rdy_pct = 100;
    prep(32'h0000_8000, 32'h10, 12);
    kick();
    begin
      int n;
      n = 0;
      while (grant_idx < 3 && n < 100) begin
        @(posedge clk);
        n++;
      end
      chk("abort_reach_issue", 32'(grant_idx >= 3), 32'd1);
    end
    #1;
    base_addr = 32'h9999_0000;
    len = CW'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(req), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_outstanding", 32'(dut.r_outstanding), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rdy_pct = 70;
    prep(32'h0000_0100, 32'd4, 6);
    kick();
    wait_done(300, "post_abort");
    chk("post_abort_beats", 32'(beat_idx), 32'd6);

    // Simultaneous grant and consume over 100 random cycles.
    gnt_pct = 50;
    rdy_pct = 50;
    both_cnt = 0;
    out_cnt = 0;
    prep(32'h0001_0000, 32'd4, 200);
    kick();
    chk_internal = 1;
    repeat (100) @(posedge clk);
    #1;
    chk_internal = 0;
    chk("simul_events_seen", 32'(both_cnt > 0), 32'd1);
    gnt_pct = 100;
    rdy_pct = 100;
    wait_done(1000, "simul");
    chk("simul_beats", 32'(beat_idx), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
